// File: rtl/au_dec_counter_pkg.sv
// Shared types for the loadable down-counter / interval timer.
package au_dec_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/au_dec_counter_if.sv
// Control/status bundle between a sequencing unit and its interval counter.
interface au_dec_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             ld_rld;
    logic             en;
    logic             stop;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             tc;

    modport master (output ld, ld_val, ld_rld, en, stop, input cnt, busy, tc);
    modport slave  (input ld, ld_val, ld_rld, en, stop, output cnt, busy, tc);
endinterface

// File: rtl/au_dec_counter_dec.sv
// Propagate-lookahead decrementer: z = a - ci, co = borrow out of the MSB.
// ARCH selects the prefix network: 0 linear, 1 Kogge-Stone, 2 Sklansky.
module AU_dec_c #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic             ci,
    output logic [WIDTH-1:0] z,
    output logic             co
);
    localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // A borrow propagates through a bit exactly when that bit is zero.
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] bin;

    assign p = ~a;

    if (ARCH == 0) begin : g_linear
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign pre[i] = &p[i:0];
        end
    end else begin : g_tree
        for (genvar l = 0; l < LV; l++) begin : g_lvl
            logic [WIDTH-1:0] prev;
            logic [WIDTH-1:0] v;
            if (l == 0) begin : g_first
                assign prev = p;
            end else begin : g_next
                assign prev = g_lvl[l-1].v;
            end
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                localparam int  D    = 1 << l;
                localparam bit  COMB = (ARCH == 1) ? (i >= D) : (((i >> l) & 1) == 1);
                localparam int  J    = !COMB ? 0 : (ARCH == 1) ? (i - D) : (((i >> l) << l) - 1);
                if (COMB) begin : g_op
                    assign v[i] = prev[i] & prev[J];
                end else begin : g_pass
                    assign v[i] = prev[i];
                end
            end
        end
        assign pre = g_lvl[LV-1].v;
    end

    if (WIDTH == 1) begin : g_w1
        assign bin = ci;
    end else begin : g_wn
        assign bin = {pre[WIDTH-2:0], 1'b1} & {WIDTH{ci}};
    end

    assign z  = a ^ bin;
    assign co = ci & pre[WIDTH-1];
endmodule

// File: rtl/au_dec_counter.sv
// Loadable down-counter with one-shot / auto-reload modes and a terminal-count pulse.
module au_dec_counter
    import au_dec_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst,
    au_dec_counter_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             ci;
    logic [WIDTH-1:0] z;
    logic             co;

    assign ci = (state_q == ST_RUN) & bus.en;

    AU_dec_c #(.WIDTH(WIDTH), .ARCH(ARCH)) u_dec (
        .a  (cnt_q),
        .ci (ci),
        .z  (z),
        .co (co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;
        // stop outranks ld in both states; a load discards any borrow this cycle.
        if (!bus.stop && bus.ld) begin
            state_d = ST_RUN;
            cnt_d   = bus.ld_val;
            rld_d   = bus.ld_val;
            mode_d  = bus.ld_rld;
        end else if (state_q == ST_RUN) begin
            if (bus.stop) begin
                state_d = ST_IDLE;
            end else if (bus.en) begin
                if (co) begin
                    tc_d = 1'b1;
                    if (mode_q) begin
                        cnt_d = rld_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = z;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rld_q   <= rld_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.tc   = tc_q;
endmodule

// File: tb/tb_au_dec_counter.sv
// Runs one shared stimulus stream into a WIDTH x ARCH grid of counters, each
// scored against its own integer reference model through an expectation queue.
module tb_au_dec_counter;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        ld     = 1'b0;
    logic [31:0] ld_val = '0;
    logic        ld_rld = 1'b0;
    logic        en     = 1'b0;
    logic        stop   = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        int unsigned cnt;
        bit          busy;
        bit          tc;
    } exp_t;

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned w, input int unsigned a,
                         input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s W=%0d ARCH=%0d t=%0t got=%0d exp=%0d", name, w, a, $time, got, exp);
    endtask

    for (genvar wi = 0; wi < 4; wi++) begin : g_w
        for (genvar ai = 0; ai < 3; ai++) begin : g_a
            localparam int unsigned W    = (wi == 0) ? 1 : (wi == 1) ? 4 : (wi == 2) ? 8 : 17;
            localparam int unsigned MASK = (32'd1 << W) - 32'd1;

            au_dec_counter_if #(.WIDTH(W)) bus ();

            assign bus.ld     = ld;
            assign bus.ld_val = ld_val[W-1:0];
            assign bus.ld_rld = ld_rld;
            assign bus.en     = en;
            assign bus.stop   = stop;

            au_dec_counter #(.WIDTH(W), .ARCH(ai)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );

            exp_t q[$];

            // Reference: a timer that is either running or not, with a remaining count.
            initial begin
                bit          running = 0;
                bit          mode    = 0;
                int unsigned remain  = 0;
                int unsigned reload  = 0;
                bit          pulse;
                exp_t        e;
                forever begin
                    @(posedge clk);
                    pulse = 0;
                    if (rst) begin
                        running = 0; mode = 0; remain = 0; reload = 0;
                    end else if (stop) begin
                        running = 0;
                    end else if (ld) begin
                        remain  = ld_val & MASK;
                        reload  = remain;
                        mode    = ld_rld;
                        running = 1;
                    end else if (running && en) begin
                        if (remain == 0) begin
                            pulse   = 1;
                            running = mode;
                            remain  = mode ? reload : 0;
                        end else begin
                            remain = remain - 1;
                        end
                    end
                    e.cnt  = remain;
                    e.busy = running;
                    e.tc   = pulse;
                    q.push_back(e);
                end
            end

            initial begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check("cnt",  W, ai, 32'(bus.cnt), e.cnt);
                        check("busy", W, ai, 32'(bus.busy), 32'(e.busy));
                        check("tc",   W, ai, 32'(bus.tc), 32'(e.tc));
                    end
                end
            end
        end
    end

    task automatic cyc(input logic l, input int unsigned v, input logic r,
                       input logic e, input logic s);
        ld = l; ld_val = v; ld_rld = r; en = e; stop = s;
        @(negedge clk);
    endtask

    initial begin
        logic en_pat [8] = '{1, 0, 1, 1, 0, 1, 1, 1};

        rst = 1'b1;
        repeat (2) cyc(1, 32'h55, 1, 1, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 1, 0);

        cyc(1, 3, 0, 1, 0);
        repeat (7) cyc(0, 0, 0, 1, 0);

        cyc(1, 2, 1, 1, 0);
        foreach (en_pat[i]) cyc(0, 0, 0, en_pat[i], 0);
        cyc(0, 0, 0, 0, 1);

        cyc(1, 0, 1, 1, 0);
        repeat (4) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);

        cyc(1, 15, 0, 1, 0);
        repeat (20) cyc(0, 0, 0, 1, 0);

        cyc(1, 2, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        cyc(1, 5, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);

        cyc(1, 9, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 7, 0, 1, 1);
        cyc(0, 0, 0, 1, 0);

        cyc(1, 9, 1, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        rst = 1'b1;
        cyc(1, 4, 1, 1, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 1, 0);

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            cyc($urandom_range(0, 7) == 0,
                ($urandom_range(0, 1) == 0) ? $urandom_range(0, 5) : $urandom,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 31) == 0);
        end
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
